// File: rtl/writeback_unit.sv
// writeback_unit: ALU/load writeback FSM (in: CLK RST ex_* mem_ack mem_rdata; out: busy reg_write write_index write_data misalign_err mem_timeout)
module writeback_unit #(
  parameter int TIMEOUT = 255
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic        ex_valid,
  input  logic        ex_is_load,
  input  logic [4:0]  ex_rd,
  input  logic [31:0] ex_result,
  input  logic [1:0]  ex_load_size,
  input  logic        ex_load_unsigned,
  input  logic [1:0]  ex_addr_low,
  input  logic        mem_ack,
  input  logic [31:0] mem_rdata,
  output logic        busy,
  output logic        reg_write,
  output logic [4:0]  write_index,
  output logic [31:0] write_data,
  output logic        misalign_err,
  output logic        mem_timeout
);
  typedef enum logic {IDLE, WAIT_MEM} state_t;
  localparam logic [7:0] LAST = 8'(TIMEOUT - 1);
  state_t state;
  logic [7:0] cnt;
  logic [4:0] rd_q;
  logic [1:0] size_q, addr_q;
  logic uns_q, misalign;
  logic [31:0] sh_b, sh_h, load_val;
  assign busy = state == WAIT_MEM;
  always_comb begin
    misalign = (ex_load_size == 2'b01 && ex_addr_low[0]) || (ex_load_size[1] && ex_addr_low != 2'b00);
    sh_b = mem_rdata >> {addr_q, 3'b000};
    sh_h = mem_rdata >> {addr_q[1], 4'b0000};
    load_val = size_q[1] ? mem_rdata :
               size_q[0] ? {{16{~uns_q & sh_h[15]}}, sh_h[15:0]} :
                           {{24{~uns_q & sh_b[7]}}, sh_b[7:0]};
  end
  always_ff @(posedge CLK) begin
    if (RST) begin
      state <= IDLE;
      cnt <= '0;
      rd_q <= '0;
      size_q <= '0;
      addr_q <= '0;
      uns_q <= 1'b0;
      reg_write <= 1'b0;
      write_index <= '0;
      write_data <= '0;
      misalign_err <= 1'b0;
      mem_timeout <= 1'b0;
    end else begin
      reg_write <= 1'b0;
      misalign_err <= 1'b0;
      if (state == IDLE) begin
        if (ex_valid && !ex_is_load) begin
          reg_write <= ex_rd != 5'd0;
          write_index <= ex_rd;
          write_data <= ex_result;
        end else if (ex_valid && misalign) begin
          misalign_err <= 1'b1;
        end else if (ex_valid) begin
          rd_q <= ex_rd;
          size_q <= ex_load_size;
          uns_q <= ex_load_unsigned;
          addr_q <= ex_addr_low;
          cnt <= '0;
          state <= WAIT_MEM;
        end
      end else if (mem_ack) begin
        reg_write <= rd_q != 5'd0;
        write_index <= rd_q;
        write_data <= load_val;
        state <= IDLE;
      end else if (cnt == LAST) begin
        mem_timeout <= 1'b1;
        state <= IDLE;
      end else begin
        cnt <= cnt + {7'd0, cnt != 8'hFF};
      end
    end
  end
endmodule
